// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back data cache controller, 4 words per line.
// Optional hit/request statistics counters are enabled with the DCACHE_STATS_EN macro.
module dcache_ctrl #(
    parameter int INDEX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        hit,
    output logic        err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] stat_req,
    output logic [15:0] stat_hit
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 13 - INDEX_W;

    typedef enum logic [1:0] {IDLE, COMPARE, WB, FILL} state_t;

    state_t state, next_state;

    logic [15:0]        data_mem [LINES*4];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid;
    logic [LINES-1:0]   dirty;

    logic [15:1]        a_q;
    logic [15:0]        wd_q;
    logic               op_wr;
    logic               filled;
    logic [1:0]         cnt;
    logic               err_q;

    logic [TAG_W-1:0]   a_tag;
    logic [INDEX_W-1:0] a_idx;
    logic [1:0]         a_word;
    logic               line_hit;
    logic               victim_dirty;
    logic               accept;
    logic               bad_req;
    logic               last_ack;

    assign a_tag        = a_q[15:3+INDEX_W];
    assign a_idx        = a_q[2+INDEX_W:3];
    assign a_word       = a_q[2:1];
    assign line_hit     = valid[a_idx] && (tag_mem[a_idx] == a_tag);
    assign victim_dirty = valid[a_idx] && dirty[a_idx];
    assign accept       = (state == IDLE) && (req_rd ^ req_wr) && !addr[0];
    assign bad_req      = (state == IDLE) && ((req_rd && req_wr) || ((req_rd ^ req_wr) && addr[0]));
    assign last_ack     = mem_ack && (cnt == 2'd3);
    assign err          = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        done       = 1'b0;
        hit        = 1'b0;
        rdata      = 16'h0000;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;
        stall      = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) next_state = COMPARE;
            end
            COMPARE: begin
                if (line_hit) begin
                    done       = 1'b1;
                    hit        = !filled;
                    rdata      = data_mem[{a_idx, a_word}];
                    next_state = IDLE;
                end else if (victim_dirty) begin
                    next_state = WB;
                end else begin
                    next_state = FILL;
                end
            end
            WB: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {tag_mem[a_idx], a_idx, cnt, 1'b0};
                mem_wdata = data_mem[{a_idx, cnt}];
                if (last_ack) next_state = FILL;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {a_tag, a_idx, cnt, 1'b0};
                if (last_ack) next_state = COMPARE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= '0;
            dirty  <= '0;
            cnt    <= 2'd0;
            err_q  <= 1'b0;
            filled <= 1'b0;
            op_wr  <= 1'b0;
            a_q    <= '0;
            wd_q   <= 16'h0000;
        end else begin
            err_q <= bad_req;
            if (accept) begin
                a_q    <= addr[15:1];
                wd_q   <= wdata;
                op_wr  <= req_wr;
                filled <= 1'b0;
            end
            if ((state == WB || state == FILL) && mem_ack) cnt <= cnt + 2'd1;
            // The line is invalid while its words are being replaced.
            if (next_state == FILL && state != FILL) begin
                valid[a_idx] <= 1'b0;
                filled       <= 1'b1;
            end
            if (state == FILL && last_ack) begin
                valid[a_idx] <= 1'b1;
                dirty[a_idx] <= 1'b0;
            end
            if (state == COMPARE && line_hit && op_wr) dirty[a_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) data_mem[{a_idx, cnt}] <= mem_rdata;
        if (state == FILL && last_ack) tag_mem[a_idx] <= a_tag;
        if (state == COMPARE && line_hit && op_wr) data_mem[{a_idx, a_word}] <= wd_q;
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req <= 16'h0000;
            stat_hit <= 16'h0000;
        end else begin
            if (accept && stat_req != 16'hFFFF) stat_req <= stat_req + 16'd1;
            if (done && hit && stat_hit != 16'hFFFF) stat_hit <= stat_hit + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl against a line-level cache model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        done, stall, hit, err;
    logic        mem_req, mem_wr, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [15:0] stat_req, stat_hit;
`endif

    always #5 clk = ~clk;

    logic [15:0] bmem      [32768];
    logic [15:0] model_mem [32768];
    bit          every3 = 1'b0;
    int          phase = 0;

    assign mem_ack   = every3 ? (mem_req && phase == 2) : 1'b1;
    assign mem_rdata = bmem[mem_addr[15:1]];

    dcache_ctrl #(.INDEX_W(5)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .stall(stall), .hit(hit), .err(err),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        , .stat_req(stat_req), .stat_hit(stat_hit)
`endif
    );

    bit          m_valid [32];
    bit          m_dirty [32];
    logic [7:0]  m_tag   [32];
    logic [15:0] m_data  [32][4];
    int          n_tests = 0;
    int          n_fail = 0;
    int          acc_n = 0;
    int          hit_n = 0;
    int          stab_err = 0;

    typedef struct packed {logic wr; logic [15:0] a; logic [15:0] d;} xfer_t;
    xfer_t log_q[$];
    xfer_t exp_q[$];

    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [15:0] prev_addr = 16'h0, prev_wd = 16'h0;

    always @(posedge clk) begin
        if (!mem_req || phase == 2) phase <= 0;
        else phase <= phase + 1;
    end

    always @(negedge clk) begin
        if (mem_req && mem_ack) begin
            log_q.push_back('{mem_wr, mem_addr, mem_wr ? mem_wdata : mem_rdata});
            if (mem_wr) bmem[mem_addr[15:1]] = mem_wdata;
        end
        if (prev_req && !prev_ack && mem_req && (mem_addr !== prev_addr || mem_wdata !== prev_wd))
            stab_err++;
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
        prev_wd   = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        acc_n = 0;
        hit_n = 0;
    endtask

    task automatic do_reset();
        req_rd = 1'b0;
        req_wr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    // Predicts the whole transaction from cache contents, then drives it and compares.
    task automatic run_req(input bit wr, input logic [15:0] a, input logic [15:0] wd, input bit slow);
        logic [4:0]  idx;
        logic [7:0]  tg;
        logic [1:0]  w, kk;
        logic [15:0] exp_rd, obs_rd;
        bit          first_hit, got;
        logic        obs_hit;
        int          nw, exp_lat, cyc, stall_n, req_n, n;
        idx = a[7:3];
        tg = a[15:8];
        w = a[2:1];
        nw = 0;
        exp_q.delete();
        first_hit = m_valid[idx] && m_tag[idx] == tg;
        if (!first_hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int k = 0; k < 4; k++) begin
                    kk = k[1:0];
                    exp_q.push_back('{1'b1, {m_tag[idx], idx, kk, 1'b0}, m_data[idx][k]});
                    model_mem[{m_tag[idx], idx, kk}] = m_data[idx][k];
                end
                nw += 4;
            end
            for (int k = 0; k < 4; k++) begin
                kk = k[1:0];
                exp_q.push_back('{1'b0, {tg, idx, kk, 1'b0}, model_mem[{tg, idx, kk}]});
                m_data[idx][k] = model_mem[{tg, idx, kk}];
            end
            nw += 4;
            m_valid[idx] = 1'b1;
            m_tag[idx] = tg;
            m_dirty[idx] = 1'b0;
        end
        exp_rd = m_data[idx][w];
        if (wr) begin
            m_data[idx][w] = wd;
            m_dirty[idx] = 1'b1;
        end
        exp_lat = first_hit ? 1 : 2 + nw * (slow ? 3 : 1);
        acc_n++;
        if (first_hit) hit_n++;

        every3 = slow;
        log_q.delete();
        stab_err = 0;
        req_rd = !wr;
        req_wr = wr;
        addr = a;
        wdata = wd;
        @(posedge clk);
        #1 req_rd = 1'b0;
        req_wr = 1'b0;
        addr = 16'($urandom);
        wdata = 16'($urandom);
        got = 1'b0; obs_hit = 1'b0; obs_rd = 16'h0;
        cyc = 0; stall_n = 0; req_n = 0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (stall) stall_n++;
            if (mem_req) req_n++;
            if (done) begin
                got = 1'b1;
                obs_hit = hit;
                obs_rd = rdata;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", cyc, exp_lat);
        chk("hit", 32'(obs_hit), 32'(first_hit));
        if (!wr) chk("rdata", 32'(obs_rd), 32'(exp_rd));
        chk("stall_cycles", stall_n, exp_lat);
        chk("mem_req_cycles", req_n, nw * (slow ? 3 : 1));
        chk("xfer_count", log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            chk("xfer_wr", 32'(log_q[k].wr), 32'(exp_q[k].wr));
            chk("xfer_addr_data", {log_q[k].a, log_q[k].d}, {exp_q[k].a, exp_q[k].d});
        end
        if (slow) chk("stable_under_backpressure", stab_err, 0);
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic check_err(input bit rd, input bit wr, input logic [15:0] a);
        req_rd = rd;
        req_wr = wr;
        addr = a;
        @(posedge clk);
        #1 req_rd = 1'b0;
        req_wr = 1'b0;
        @(negedge clk);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_stall", 32'(stall), 32'd0);
        chk("err_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_still_idle", 32'(stall), 32'd0);
`ifdef DCACHE_STATS_EN
        chk("err_stat_req", 32'(stat_req), acc_n);
`endif
    endtask

    task automatic rst_mid_fill(input logic [15:0] a);
        int cyc;
        bit seen;
        cyc = 0;
        seen = 1'b0;
        every3 = 1'b0;
        req_rd = 1'b1;
        addr = a;
        @(posedge clk);
        #1 req_rd = 1'b0;
        while (!seen && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (mem_req && !mem_wr && mem_addr[2:1] == 2'd2) seen = 1'b1;
        end
        chk("fill_word2_reached", 32'(seen), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_drops_mem_req", 32'(mem_req), 32'd0);
        chk("rst_idle_stall", 32'(stall), 32'd0);
        chk("rst_no_done", 32'(done), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tgs [4];
        logic [7:0] tg;
        logic [4:0] idx;
        logic [1:0] w;
        tgs[0] = 8'h00; tgs[1] = 8'h01; tgs[2] = 8'h02; tgs[3] = 8'hA5;
        for (int i = 0; i < 32768; i++) begin
            bmem[i] = 16'($urandom);
            model_mem[i] = bmem[i];
        end

        do_reset();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        run_req(1'b0, 16'h0010, 16'h0000, 1'b0);
        run_req(1'b0, 16'h0012, 16'h0000, 1'b0);
        run_req(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        run_req(1'b0, 16'h0110, 16'h0000, 1'b0);
        chk("wb_beef_in_memory", 32'(bmem[15'h0008]), 32'h0000BEEF);
        run_req(1'b0, 16'h0220, 16'h0000, 1'b1);

        check_err(1'b1, 1'b1, 16'h0040);
        check_err(1'b1, 1'b0, 16'h0011);

        do_reset();
        rst_mid_fill(16'h0030);
        run_req(1'b0, 16'h0030, 16'h0000, 1'b0);

        for (int t = 0; t < 80; t++) begin
            tg = tgs[$urandom_range(0, 3)];
            idx = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            w = 2'($urandom);
            if ($urandom_range(0, 9) == 0)
                check_err(1'b1, ($urandom_range(0, 1) == 1), {tg, idx, w, 1'b1});
            else
                run_req(($urandom_range(0, 1) == 1), {tg, idx, w, 1'b0}, 16'($urandom),
                        ($urandom_range(0, 3) == 0));
        end

`ifdef DCACHE_STATS_EN
        chk("stat_req_total", 32'(stat_req), acc_n);
        chk("stat_hit_total", 32'(stat_hit), hit_n);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The module SHALL have one clock and synchronous active-high reset: clk is the single clock, all state updates on its rising edge; rst is synchronous, active-high.
REQ-002 The module SHALL have parameter INDEX_W, default 5, meaning index bits, giving 2^INDEX_W lines.
REQ-003 Each line SHALL hold 4 words (8 bytes) and one tag.
REQ-004 The address split SHALL be: tag = addr[15:3+INDEX_W], index = addr[2+INDEX_W:3], word = addr[2:1], addr[0] = alignment bit.
REQ-005 The module SHALL have ports exactly as follows (name, direction, width, meaning):
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  req_rd  in  1  load request from memory stage
  req_wr  in  1  store request from memory stage
  addr  in  16  byte address
  wdata  in  16  store data
  rdata  out  16  load data, valid when done=1
  done  out  1  one-cycle completion pulse
  stall  out  1  controller busy, pipeline must freeze
  hit  out  1  completion was a first-lookup hit (DCacheHit source)
  err  out  1  one-cycle pulse for a rejected request
  mem_req  out  1  backing-memory word request
  mem_wr  out  1  1 = write, 0 = read
  mem_addr  out  16  backing-memory word address
  mem_wdata  out  16  write-back data
  mem_ack  in  1  backing memory accepts/returns the word this cycle
  mem_rdata  in  16  fill data, valid with mem_ack

Function
REQ-006 In IDLE the module SHALL accept a request when exactly one of req_rd/req_wr is 1, registering addr/wdata/op at that edge; the requester need not hold inputs afterwards.
REQ-007 If both req_rd and req_wr are 1, or addr[0]=1, the module SHALL pulse err for 1 cycle (the cycle after sampling), perform no access, and stay in IDLE.
REQ-008 Requests presented while stall=1 SHALL be ignored.
REQ-009 States SHALL be IDLE, COMPARE, WB, FILL: IDLE -> COMPARE on accept; COMPARE -> IDLE on hit; COMPARE -> WB on miss with valid and dirty victim; COMPARE -> FILL on miss with clean or invalid victim; WB -> FILL after word 3 is acked; FILL -> COMPARE after word 3 is acked.
REQ-010 stall SHALL be 1 in every state except IDLE.
REQ-011 A hit in COMPARE SHALL assert done for that cycle.
REQ-012 On a load hit, rdata SHALL equal the addressed word in the same cycle as done.
REQ-013 On a store hit, the word SHALL be written and the dirty bit set at the end of that cycle.
REQ-014 On a hit, hit SHALL be 1 if no fill occurred for this request, else 0; first-lookup hit latency is 1 cycle after accept.
REQ-015 WB SHALL issue words 0..3 in order with mem_wr=1, mem_addr={victim tag, index, word, 1'b0} and mem_wdata = victim word; mem_req SHALL be held with address/data stable until mem_ack, then advance next cycle.
REQ-016 FILL SHALL issue words 0..3 in order with mem_wr=0, mem_addr={new tag, index, word, 1'b0}, writing mem_rdata into the line on each mem_ack.
REQ-017 After word 3 of a fill, the line SHALL become valid with the new tag and dirty=0.
REQ-018 mem_ack SHALL be ignored while mem_req=0.
REQ-019 mem_req SHALL be 0 in IDLE and COMPARE.
REQ-020 Zero-wait memory (mem_ack tied 1) SHALL give a dirty-miss latency of 1+4+4+1 = 10 cycles from accept to done.

Reset
REQ-021 On rst, the module SHALL set state to IDLE, clear all valid and dirty bits, and clear the word counter.
REQ-022 On rst, the module SHALL drive done, hit, err, stall, mem_req, mem_wr to 0, and rdata, mem_addr, mem_wdata to 0.
REQ-023 rst asserted mid-WB or mid-FILL SHALL abort the transfer, dropping mem_req in the cycle after the reset edge, and no partially filled line SHALL be valid afterwards.
REQ-024 Tag and data arrays SHALL need no reset.

Configuration
REQ-025 With macro DCACHE_STATS_EN defined, the module SHALL add outputs stat_req (16) and stat_hit (16), reset to 0.
REQ-026 With DCACHE_STATS_EN defined, stat_req SHALL increment on each accepted legal request and stat_hit on each done with hit=1, both saturating at 0xFFFF.
REQ-027 Without DCACHE_STATS_EN, those ports and counters SHALL be absent and the remaining behaviour SHALL be unchanged.

Verification
REQ-028 Bench SHALL cover cold load, mem_ack=1: after rst, load 0x0010 -> FILL addresses 0x0010,0x0012,0x0014,0x0016; done with hit=0 6 cycles after accept; rdata = memory[0x0010].
REQ-029 Bench SHALL cover a repeat load hit: load 0x0012 immediately after -> done and hit=1 1 cycle after accept; stall high exactly 1 cycle; mem_req never asserted.
REQ-030 Bench SHALL cover dirty eviction, INDEX_W=5: store 0xBEEF to 0x0010, then load 0x0110 -> WB writes 0xBEEF to 0x0010 among 4 writes, then 4 reads from 0x0110, done at cycle 10.
REQ-031 Bench SHALL cover backpressure: mem_ack asserted only every 3rd cycle during FILL -> mem_addr/mem_req held stable between acks; done at cycle 1+12+1 = 14.
REQ-032 Bench SHALL cover illegal requests: req_rd=req_wr=1, then load 0x0011 -> err pulses each time, no mem_req, stall stays 0; with DCACHE_STATS_EN, stat_req unchanged.
REQ-033 Bench SHALL cover reset mid-FILL: rst during word 2 -> mem_req 0 the next cycle; the same load then misses again (hit=0).
